// File: rtl/dec_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dec_alu_pipe
// Purpose  : Decode-to-ALU pipeline stage with a two-entry skid buffer,
//            flush, load-use hazard stalling and a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module dec_alu_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  inWbEn,
  input  logic                  inMemRd,
  input  logic                  inMemWr,
  input  logic [REG_ADDR_W-1:0] inWbAddr,
  input  logic [REG_ADDR_W-1:0] inRs1Addr,
  input  logic [REG_ADDR_W-1:0] inRs2Addr,
  input  logic                  inUseRs1,
  input  logic                  inUseRs2,
  input  logic [DATA_W-1:0]     inData1,
  input  logic [DATA_W-1:0]     inData2,
  input  logic [DATA_W-1:0]     inImm,
  input  logic [ALU_OP_W-1:0]   inOp,
  input  logic                  flush,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outWbEn,
  output logic                  outMemRd,
  output logic                  outMemWr,
  output logic [REG_ADDR_W-1:0] outWbAddr,
  output logic [DATA_W-1:0]     outData1,
  output logic [DATA_W-1:0]     outData2,
  output logic [DATA_W-1:0]     outImm,
  output logic [ALU_OP_W-1:0]   outOp,
  output logic [CNT_W-1:0]      bubbleCount
);

  // Packed bundle: {wbEn, memRd, memWr, wbAddr, data1, data2, imm, op}
  localparam int c_PW = 3 + REG_ADDR_W + 3 * DATA_W + ALU_OP_W;

  logic [c_PW-1:0]  w_in_bundle;
  logic [c_PW-1:0]  r_m;
  logic [c_PW-1:0]  r_s;
  logic             r_mv;
  logic             r_sv;
  logic [CNT_W-1:0] r_bubbles;
  logic             w_load_use;
  logic             w_in_take;
  logic             w_out_take;
  logic             w_rs1_hit;
  logic             w_rs2_hit;

  assign w_in_bundle = {inWbEn, inMemRd, inMemWr, inWbAddr,
                        inData1, inData2, inImm, inOp};

  assign {outWbEn, outMemRd, outMemWr, outWbAddr,
          outData1, outData2, outImm, outOp} = r_m;

  assign outValid    = r_mv;
  assign bubbleCount = r_bubbles;

  // A load in M whose destination is read by the incoming bundle blocks it;
  // register 0 is never a real dependency.
  assign w_rs1_hit  = inUseRs1 && (inRs1Addr == outWbAddr);
  assign w_rs2_hit  = inUseRs2 && (inRs2Addr == outWbAddr);
  assign w_load_use = r_mv && outMemRd && outWbEn && (outWbAddr != '0) &&
                      (w_rs1_hit || w_rs2_hit);

  assign inReady    = rst_n && !flush && !r_sv && !w_load_use;
  assign w_in_take  = inValid && inReady;
  assign w_out_take = r_mv && outReady;

  // Main/skid occupancy and payload movement, oldest entry always in M.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mv <= 1'b0;
      r_sv <= 1'b0;
      r_m  <= '0;
      r_s  <= '0;
    end else if (flush) begin
      r_mv <= 1'b0;
      r_sv <= 1'b0;
    end else if (!r_mv) begin
      if (w_in_take) begin
        r_m  <= w_in_bundle;
        r_mv <= 1'b1;
      end
    end else if (w_out_take) begin
      if (r_sv) begin
        r_m  <= r_s;
        r_sv <= 1'b0;
      end else if (w_in_take) begin
        r_m  <= w_in_bundle;
      end else begin
        r_mv <= 1'b0;
      end
    end else if (w_in_take) begin
      r_s  <= w_in_bundle;
      r_sv <= 1'b1;
    end
  end

  // Saturating count of cycles a valid bundle was stalled by a load-use hazard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubbles <= '0;
    end else if (inValid && w_load_use && !flush && (r_bubbles != '1)) begin
      r_bubbles <= r_bubbles + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_alu_pipe
// Purpose  : Directed self-checking bench for dec_alu_pipe (streaming,
//            backpressure, load-use, flush, reset, counter saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inReady, inReady_s;
  logic        inWbEn, inMemRd, inMemWr;
  logic [4:0]  inWbAddr, inRs1Addr, inRs2Addr;
  logic        inUseRs1, inUseRs2;
  logic [31:0] inData1, inData2, inImm;
  logic [3:0]  inOp;
  logic        flush;
  logic        outValid, outReady;
  logic        outWbEn, outMemRd, outMemWr;
  logic [4:0]  outWbAddr;
  logic [31:0] outData1, outData2, outImm;
  logic [3:0]  outOp;
  logic [15:0] bubbleCount;

  // Second instance with a 2-bit counter, fed the same stimulus.
  logic        outValid_s, outWbEn_s, outMemRd_s, outMemWr_s;
  logic [4:0]  outWbAddr_s;
  logic [31:0] outData1_s, outData2_s, outImm_s;
  logic [3:0]  outOp_s;
  logic [1:0]  bubbleCount_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dec_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inWbEn(inWbEn), .inMemRd(inMemRd), .inMemWr(inMemWr),
    .inWbAddr(inWbAddr), .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr),
    .inUseRs1(inUseRs1), .inUseRs2(inUseRs2),
    .inData1(inData1), .inData2(inData2), .inImm(inImm), .inOp(inOp),
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .outWbEn(outWbEn), .outMemRd(outMemRd), .outMemWr(outMemWr),
    .outWbAddr(outWbAddr), .outData1(outData1), .outData2(outData2),
    .outImm(outImm), .outOp(outOp), .bubbleCount(bubbleCount)
  );

  dec_alu_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady_s),
    .inWbEn(inWbEn), .inMemRd(inMemRd), .inMemWr(inMemWr),
    .inWbAddr(inWbAddr), .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr),
    .inUseRs1(inUseRs1), .inUseRs2(inUseRs2),
    .inData1(inData1), .inData2(inData2), .inImm(inImm), .inOp(inOp),
    .flush(flush), .outValid(outValid_s), .outReady(outReady),
    .outWbEn(outWbEn_s), .outMemRd(outMemRd_s), .outMemWr(outMemWr_s),
    .outWbAddr(outWbAddr_s), .outData1(outData1_s), .outData2(outData2_s),
    .outImm(outImm_s), .outOp(outOp_s), .bubbleCount(bubbleCount_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d1, input logic rd, input logic wb,
                      input logic [4:0] wba, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2);
    logic [31:0] t;
    t         = d1;
    inValid   = 1'b1;
    inData1   = d1;
    inData2   = d1 + 32'd100;
    inImm     = ~d1;
    inOp      = t[3:0];
    inMemRd   = rd;
    inMemWr   = 1'b0;
    inWbEn    = wb;
    inWbAddr  = wba;
    inRs1Addr = rs1;
    inUseRs1  = u1;
    inRs2Addr = rs2;
    inUseRs2  = u2;
  endtask

  task automatic idle();
    inValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; outReady = 1'b1;
    send(32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    tick(); tick();

    // Reset state
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_inReady", 64'(inReady), 64'd0);
    chk("rst_bubble", 64'(bubbleCount), 64'd0);
    chk("rst_data1", 64'(outData1), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_inReady", 64'(inReady), 64'd1);

    // Streaming 1..8, each visible one cycle after acceptance
    for (int i = 1; i <= 8; i++) begin
      send(32'(i), 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      chk("stream_valid", 64'(outValid), 64'd1);
      chk("stream_data1", 64'(outData1), 64'(i));
    end
    chk("stream_data2", 64'(outData2), 64'd108);
    idle();
    tick();
    chk("stream_drain", 64'(outValid), 64'd0);
    chk("stream_bubble", 64'(bubbleCount), 64'd0);

    // Backpressure: 3 cycles of outReady=0
    send(32'd11, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    outReady = 1'b0;
    send(32'd12, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("bp_ready_skid_free", 64'(inReady), 64'd1);
    tick();
    send(32'd13, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("bp_ready_full", 64'(inReady), 64'd0);
    tick(); tick();
    chk("bp_hold_data", 64'(outData1), 64'd11);
    chk("bp_hold_ready", 64'(inReady), 64'd0);
    outReady = 1'b1;
    tick();
    chk("bp_skid_out", 64'(outData1), 64'd12);
    chk("bp_ready_back", 64'(inReady), 64'd1);
    tick();
    chk("bp_next_out", 64'(outData1), 64'd13);
    idle();
    tick();
    chk("bp_drain", 64'(outValid), 64'd0);

    // Load-use with a real dependency on r5
    send(32'd21, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd22, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    chk("lu_blocked", 64'(inReady), 64'd0);
    chk("lu_load_out", 64'(outData1), 64'd21);
    tick();
    chk("lu_bubble_cycle", 64'(outValid), 64'd0);
    chk("lu_count", 64'(bubbleCount), 64'd1);
    tick();
    chk("lu_dep_out", 64'(outData1), 64'd22);
    chk("lu_dep_valid", 64'(outValid), 64'd1);
    idle();
    tick();

    // Load to r0: no hazard
    send(32'd31, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd32, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b1);
    #1;
    chk("lu_r0_ready", 64'(inReady), 64'd1);
    tick();
    chk("lu_r0_out", 64'(outData1), 64'd32);

    // Load to r5 but rs2 unused: no hazard
    send(32'd41, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd42, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd5, 1'b0);
    #1;
    chk("lu_nouse_ready", 64'(inReady), 64'd1);
    tick();
    chk("lu_nouse_out", 64'(outData1), 64'd42);
    idle();
    tick();
    chk("lu_count_kept", 64'(bubbleCount), 64'd1);

    // Flush with M and S full
    outReady = 1'b0;
    send(32'd51, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd52, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    flush = 1'b1;
    send(32'd53, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("fl_ready", 64'(inReady), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    outReady = 1'b1;
    chk("fl_valid", 64'(outValid), 64'd0);
    send(32'd54, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("fl_next_out", 64'(outData1), 64'd54);
    chk("fl_next_valid", 64'(outValid), 64'd1);
    idle();
    tick();
    chk("fl_no_ghost", 64'(outValid), 64'd0);

    // Reset mid-stream with S full
    outReady = 1'b0;
    send(32'd61, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd62, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    send(32'd63, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("mrst_ready", 64'(inReady), 64'd0);
    tick();
    chk("mrst_valid", 64'(outValid), 64'd0);
    chk("mrst_data1", 64'(outData1), 64'd0);
    chk("mrst_op", 64'(outOp), 64'd0);
    chk("mrst_bubble", 64'(bubbleCount), 64'd0);
    chk("mrst_bubble_s", 64'(bubbleCount_s), 64'd0);
    rst_n = 1'b1;
    idle();
    outReady = 1'b1;
    tick();
    chk("mrst_after", 64'(outValid), 64'd0);

    // Saturation: load to r7 stalled 5 cycles with dependent waiting
    outReady = 1'b0;
    send(32'd71, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    send(32'd72, 1'b0, 1'b1, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_big", 64'(bubbleCount), 64'd5);
    chk("sat_small", 64'(bubbleCount_s), 64'd3);
    outReady = 1'b1;
    tick();
    tick();
    chk("sat_dep_out", 64'(outData1), 64'd72);
    chk("sat_small_hold", 64'(bubbleCount_s), 64'd3);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
